// File: rtl/mem_access_mc.sv
// Multi-bank burst read engine for the image/kernel ROMs.
// Takes one request (bank, base address, row/column mode) and issues BEATS reads
// to a synchronous-read bank. It packs the returned words into one wide response
// and holds that response until the consumer takes it. Only one request is
// outstanding at a time.
module mem_access_mc #(
  parameter int NUM_BANKS  = 2,
  parameter int WORD_W     = 16,
  parameter int BEATS      = 3,
  parameter int ADDR_W     = 19,
  parameter int MEM_LAT    = 1,
  parameter int ROW_STRIDE = 640,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        REQ_VALID,
  output logic                        REQ_READY,
  input  logic [BANK_W-1:0]           REQ_BANK,
  input  logic                        REQ_MODE,
  input  logic [ADDR_W-1:0]           REQ_ADDR,
  output logic                        RSP_VALID,
  input  logic                        RSP_READY,
  output logic [BEATS*WORD_W-1:0]     RSP_DATA,
  output logic                        RSP_ERR,
  output logic [NUM_BANKS-1:0]        MEM_EN,
  output logic [ADDR_W-1:0]           MEM_ADDR,
  input  logic [NUM_BANKS*WORD_W-1:0] MEM_RDATA
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADDR_W-1:0] STRIDE_COL = ADDR_W'(ROW_STRIDE);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t              state, state_nxt;
  logic [BANK_W-1:0]   bank_q;
  logic [ADDR_W-1:0]   stride_q;
  logic [CNT_W-1:0]    issue_cnt;
  logic [CNT_W-1:0]    cap_cnt;
  // rd_vld_p[k] is high when the read issued k+1 cycles ago is in flight
  logic [MEM_LAT-1:0]  rd_vld_p;
  logic                accept;
  logic                bad_bank;
  logic                cap_fire;
  logic                last_issue;
  logic                last_cap;

  assign REQ_READY  = (state == IDLE);
  assign RSP_VALID  = (state == DONE);
  assign accept     = REQ_VALID & REQ_READY;
  assign bad_bank   = 32'(REQ_BANK) >= 32'(NUM_BANKS);
  assign cap_fire   = rd_vld_p[MEM_LAT-1] && ((state == ISSUE) || (state == DRAIN));
  assign last_issue = (issue_cnt == CNT_W'(BEATS - 1));
  assign last_cap   = cap_fire && (cap_cnt == CNT_W'(BEATS - 1));

  // State register; reset overrides any handshake in the same cycle
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: a bad bank skips the memory entirely and answers at once
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bad_bank ? DONE : ISSUE;
      ISSUE:   if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (last_cap) state_nxt = DONE;
      DONE:    if (RSP_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Issue stage: latch the request, then step the address once per beat
  always_ff @(posedge CLK) begin
    if (RESET) begin
      MEM_EN    <= '0;
      MEM_ADDR  <= '0;
      issue_cnt <= '0;
      bank_q    <= '0;
      stride_q  <= '0;
    end else if (accept) begin
      bank_q    <= REQ_BANK;
      stride_q  <= REQ_MODE ? STRIDE_COL : ADDR_W'(1);
      issue_cnt <= '0;
      if (!bad_bank) begin
        MEM_EN   <= NUM_BANKS'(1) << REQ_BANK;
        MEM_ADDR <= REQ_ADDR;
      end
    end else if (state == ISSUE) begin
      if (last_issue) begin
        MEM_EN <= '0;
      end else begin
        MEM_ADDR  <= MEM_ADDR + stride_q;
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
    end
  end

  // Capture stage: reads return MEM_LAT cycles after issue, packed beat 0 lowest
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_vld_p <= '0;
      cap_cnt  <= '0;
      RSP_DATA <= '0;
      RSP_ERR  <= 1'b0;
    end else begin
      rd_vld_p[0] <= |MEM_EN;
      for (int k = MEM_LAT - 1; k > 0; k--) rd_vld_p[k] <= rd_vld_p[k-1];
      if (accept) begin
        cap_cnt  <= '0;
        RSP_DATA <= '0;
        RSP_ERR  <= bad_bank;
      end else if (cap_fire) begin
        RSP_DATA[cap_cnt*WORD_W +: WORD_W] <= MEM_RDATA[bank_q*WORD_W +: WORD_W];
        cap_cnt <= cap_cnt + CNT_W'(1);
      end
    end
  end

endmodule
